// File: rtl/player_input_conditioner_pkg.sv
// Shared button bit-index constants for the player input path and the game core.
// Also holds the debounce counter width helper.
package input_pkg;
   localparam int NUM_BTNS   = 7;
   localparam int BTN_CENTER = 0;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_RIGHT  = 2;
   localparam int BTN_UP     = 3;
   localparam int BTN_DOWN   = 4;
   localparam int BTN_ATTACK = 5;
   localparam int BTN_SHIELD = 6;

   function automatic int cnt_width(input int cycles);
      return (cycles <= 1) ? 1 : $clog2(cycles);
   endfunction
endpackage

// File: rtl/player_input_conditioner_if.sv
// Button bus between the raw input pins and the game core.
// The master side drives raw levels; the slave side is the conditioner.
interface player_input_conditioner_if;
   logic [input_pkg::NUM_BTNS-1:0] raw_btns;
   logic [input_pkg::NUM_BTNS-1:0] player_inputs;
   logic                           any_press;

   modport master (output raw_btns, input player_inputs, input any_press);
   modport slave  (input raw_btns, output player_inputs, output any_press);
endinterface

// File: rtl/player_input_conditioner_debounce_cell.sv
// One button lane: two-flop synchroniser followed by a consecutive-cycle debounce counter.
// Any single cycle of agreement with the stable level clears the count.
module debounce_cell
   import input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable
);
   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/player_input_conditioner.sv
// Per-player button conditioner: debounced lanes, direction/attack conflict resolution, any-press strobe.
// Define INPUT_ATTACK_ONESHOT_EN to turn the attack output into a single pulse per debounced press.
module player_input_conditioner
   import input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input logic                       clk,
   input logic                       reset,
   player_input_conditioner_if.slave bus
);
   logic [NUM_BTNS-1:0] stable;
   logic [NUM_BTNS-1:0] stable_d;
   logic [NUM_BTNS-1:0] resolved;
   logic [NUM_BTNS-1:0] rose;

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_lane
      debounce_cell #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
         .clk    (clk),
         .reset  (reset),
         .raw    (bus.raw_btns[i]),
         .stable (stable[i])
      );
   end

   assign rose = stable & ~stable_d;

   always_comb begin
      resolved             = stable;
      resolved[BTN_CENTER] = stable[BTN_CENTER];
      if (stable[BTN_LEFT] && stable[BTN_RIGHT]) begin
         resolved[BTN_LEFT]  = 1'b0;
         resolved[BTN_RIGHT] = 1'b0;
      end
      if (stable[BTN_UP] && stable[BTN_DOWN]) begin
         resolved[BTN_UP]   = 1'b0;
         resolved[BTN_DOWN] = 1'b0;
      end
`ifdef INPUT_ATTACK_ONESHOT_EN
      // Only the attack rise itself counts; shield release never re-arms a pulse.
      resolved[BTN_ATTACK] = rose[BTN_ATTACK] & ~stable[BTN_SHIELD];
`else
      resolved[BTN_ATTACK] = stable[BTN_ATTACK] & ~stable[BTN_SHIELD];
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable_d          <= '0;
         bus.player_inputs <= '0;
         bus.any_press     <= 1'b0;
      end else begin
         stable_d          <= stable;
         bus.player_inputs <= resolved;
         bus.any_press     <= |rose;
      end
   end
endmodule
